// File: rtl/vram_pkg.sv
// Shared sizes, defaults and FSM state type for the VRAM arbiter.
// The SCROLL state exists only when VRAM_SCROLL_EN is defined.
package vram_pkg;
    localparam int COLS_DEF   = 70;
    localparam int ROWS_DEF   = 30;
    localparam logic [7:0] BLANK_DEF = 8'h20;
    localparam int VRAM_DEPTH = 2100;
    localparam int ADDR_W     = 12;
    localparam int X_W        = 7;
    localparam int Y_W        = 5;
    localparam int DATA_W     = 8;

`ifdef VRAM_SCROLL_EN
    typedef enum logic [1:0] {IDLE, CLEAR, SCROLL} state_t;
`else
    typedef enum logic [1:0] {IDLE, CLEAR} state_t;
`endif
endpackage

// File: rtl/vram_if.sv
// Display, writer, clear and memory-port signals of the VRAM arbiter.
// scroll_req is present only when VRAM_SCROLL_EN is defined.
interface vram_if;
    import vram_pkg::*;

`ifdef VRAM_SCROLL_EN
    logic              scroll_req;
`endif
    logic              disp_req;
    logic [X_W-1:0]    disp_x;
    logic [Y_W-1:0]    disp_y;
    logic [DATA_W-1:0] disp_data;
    logic              disp_vld;
    logic              wr_valid;
    logic              wr_ready;
    logic [X_W-1:0]    wr_x;
    logic [Y_W-1:0]    wr_y;
    logic [DATA_W-1:0] wr_char;
    logic              wr_err;
    logic              clr_start;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
`ifdef VRAM_SCROLL_EN
        output scroll_req,
`endif
        output disp_req, disp_x, disp_y, wr_valid, wr_x, wr_y, wr_char,
        output clr_start, mem_rdata,
        input  disp_data, disp_vld, wr_ready, wr_err, busy,
        input  mem_addr, mem_we, mem_wdata
    );

    modport slave (
`ifdef VRAM_SCROLL_EN
        input  scroll_req,
`endif
        input  disp_req, disp_x, disp_y, wr_valid, wr_x, wr_y, wr_char,
        input  clr_start, mem_rdata,
        output disp_data, disp_vld, wr_ready, wr_err, busy,
        output mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vram_addr_calc.sv
// Logical (x, y) to physical VRAM address: row = (y + row_base) mod ROWS,
// addr = row*COLS + x. Inputs are assumed in range; callers qualify the result.
module vram_addr_calc
    import vram_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF
) (
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    input  logic [Y_W-1:0]    row_base,
    output logic [ADDR_W-1:0] addr
);
    localparam logic [Y_W:0]    ROWS_W = (Y_W+1)'(ROWS);
    localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);

    logic [Y_W:0]   row_sum;
    logic [Y_W:0]   row_wrap;
    logic [Y_W-1:0] row;

    always_comb begin
        row_sum  = {1'b0, y} + {1'b0, row_base};
        row_wrap = row_sum - ROWS_W;
        if (row_sum >= ROWS_W) begin
            row = row_wrap[Y_W-1:0];
        end else begin
            row = row_sum[Y_W-1:0];
        end
        addr = ADDR_W'(row) * COLS_A + ADDR_W'(x);
    end
endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display read > clear/scroll sweep > writer, one access per cycle.
// Optional row scrolling (scroll_req, SCROLL state, row_base) is built with VRAM_SCROLL_EN.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF,
    parameter logic [DATA_W-1:0] BLANK_CHAR = BLANK_DEF
) (
    input  logic  pclk,
    input  logic  reset_n,
    vram_if.slave bus
);
    localparam logic [X_W-1:0] COLS_X = X_W'(COLS);
    localparam logic [X_W-1:0] LAST_X = X_W'(COLS - 1);
    localparam logic [Y_W-1:0] ROWS_Y = Y_W'(ROWS);
    localparam logic [Y_W-1:0] LAST_Y = Y_W'(ROWS - 1);

    state_t            state, state_n;
    logic              run;
    logic [X_W-1:0]    sweep_x;
    logic [Y_W-1:0]    sweep_y;
    logic [Y_W-1:0]    row_base;
    logic [ADDR_W-1:0] disp_addr, wr_addr, sweep_addr;
    logic              disp_oob, wr_oob, wr_fire;
    logic              sweep_adv, sweep_last, clr_go;
    logic              disp_vld_p0, disp_oob_p0, wr_err_p0;

    vram_addr_calc #(.COLS(COLS), .ROWS(ROWS)) u_disp_addr (
        .x(bus.disp_x), .y(bus.disp_y), .row_base(row_base), .addr(disp_addr)
    );
    vram_addr_calc #(.COLS(COLS), .ROWS(ROWS)) u_wr_addr (
        .x(bus.wr_x), .y(bus.wr_y), .row_base(row_base), .addr(wr_addr)
    );
    // Sweep counters already hold physical coordinates.
    vram_addr_calc #(.COLS(COLS), .ROWS(ROWS)) u_sweep_addr (
        .x(sweep_x), .y(sweep_y), .row_base('0), .addr(sweep_addr)
    );

    assign disp_oob      = (bus.disp_x >= COLS_X) || (bus.disp_y >= ROWS_Y);
    assign wr_oob        = (bus.wr_x >= COLS_X) || (bus.wr_y >= ROWS_Y);
    assign bus.busy      = (state != IDLE);
    // run holds every output quiet until the first edge after reset release.
    assign bus.wr_ready  = run && (state == IDLE) && !bus.disp_req && !bus.clr_start;
    assign wr_fire       = bus.wr_valid && bus.wr_ready;
    assign sweep_adv     = run && (state != IDLE) && !bus.disp_req;
    assign sweep_last    = (sweep_x == LAST_X) && ((state != CLEAR) || (sweep_y == LAST_Y));
    assign clr_go        = run && (state == IDLE) && bus.clr_start;

`ifdef VRAM_SCROLL_EN
    logic scroll_go;
    assign scroll_go = run && (state == IDLE) && bus.scroll_req && !bus.clr_start;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            row_base <= '0;
        end else if (clr_go) begin
            row_base <= '0;
        end else if (scroll_go) begin
            row_base <= (row_base == LAST_Y) ? '0 : row_base + 1'b1;
        end
    end
`else
    assign row_base = '0;
`endif

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n       = state;
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        case (state)
            IDLE: begin
                if (clr_go) begin
                    state_n = CLEAR;
`ifdef VRAM_SCROLL_EN
                end else if (scroll_go) begin
                    state_n = SCROLL;
`endif
                end
            end
            default: begin
                if (sweep_adv && sweep_last) begin
                    state_n = IDLE;
                end
            end
        endcase
        if (run) begin
            if (bus.disp_req) begin
                if (!disp_oob) begin
                    bus.mem_addr = disp_addr;
                end
            end else if (state != IDLE) begin
                bus.mem_addr  = sweep_addr;
                bus.mem_we    = 1'b1;
                bus.mem_wdata = BLANK_CHAR;
            end else if (wr_fire && !wr_oob) begin
                bus.mem_addr  = wr_addr;
                bus.mem_we    = 1'b1;
                bus.mem_wdata = bus.wr_char;
            end
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            run     <= 1'b0;
            sweep_x <= '0;
            sweep_y <= '0;
        end else begin
            run <= 1'b1;
            if (clr_go) begin
                sweep_x <= '0;
                sweep_y <= '0;
`ifdef VRAM_SCROLL_EN
            end else if (scroll_go) begin
                sweep_x <= '0;
                sweep_y <= row_base;
`endif
            end else if (sweep_adv) begin
                if (sweep_last) begin
                    sweep_x <= '0;
                    sweep_y <= '0;
                end else if (sweep_x == LAST_X) begin
                    sweep_x <= '0;
                    sweep_y <= sweep_y + 1'b1;
                end else begin
                    sweep_x <= sweep_x + 1'b1;
                end
            end
        end
    end

    // p0: read data returns from the VRAM one cycle after the request.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            disp_vld_p0 <= 1'b0;
            disp_oob_p0 <= 1'b0;
            wr_err_p0   <= 1'b0;
        end else begin
            disp_vld_p0 <= run && bus.disp_req;
            disp_oob_p0 <= disp_oob;
            wr_err_p0   <= wr_fire && wr_oob;
        end
    end

    assign bus.disp_vld  = disp_vld_p0;
    assign bus.disp_data = !disp_vld_p0 ? '0 : (disp_oob_p0 ? BLANK_CHAR : bus.mem_rdata);
    assign bus.wr_err    = wr_err_p0;
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: constant vector table, corner-case sequences and random traffic
// checked against a cell-array/queue model of the screen. Scroll tests need VRAM_SCROLL_EN.
module tb_vram_arbiter;
    import vram_pkg::*;

    localparam int C = 70;
    localparam int R = 30;
    localparam logic [7:0] BL = 8'h20;

    logic pclk = 1'b0;
    logic reset_n = 1'b0;
    logic mem_init = 1'b1;

    vram_if vif();

    vram_arbiter #(.COLS(C), .ROWS(R), .BLANK_CHAR(BL)) dut (
        .pclk(pclk), .reset_n(reset_n), .bus(vif)
    );

    always #5 pclk = ~pclk;

    logic [7:0] vram [0:4095];
    always @(posedge pclk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) vram[i] <= 8'hFF;
        end else if (vif.mem_we) begin
            vram[vif.mem_addr] <= vif.mem_wdata;
        end
        vif.mem_rdata <= vram[vif.mem_addr];
    end

    int checks = 0;
    int errors = 0;
    logic [7:0] shadow [0:VRAM_DEPTH-1];
    int sq[$];
    int m_rb;
    bit m_live, m_dv, m_werr;
    logic [7:0] m_dd;

    typedef struct {
        bit dreq; int dx; int dy;
        bit wv; int wx; int wy; int wc;
        bit e_rdy; bit e_we; int e_addr; int e_wd; bit e_dv; int e_dd; bit e_err;
    } vec_t;
    vec_t tbl[14];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int paddr(input int x, input int y);
        return ((y + m_rb) % R) * C + x;
    endfunction

    task automatic drive(input bit dreq, input int dx, input int dy, input bit wv,
                         input int wx, input int wy, input int wc, input bit clr);
        vif.disp_req  = dreq;
        vif.disp_x    = 7'(dx);
        vif.disp_y    = 5'(dy);
        vif.wr_valid  = wv;
        vif.wr_x      = 7'(wx);
        vif.wr_y      = 5'(wy);
        vif.wr_char   = 8'(wc);
        vif.clr_start = clr;
    endtask

    task automatic set_scroll(input bit s);
`ifdef VRAM_SCROLL_EN
        vif.scroll_req = s;
`else
        if (s) $display("scroll request ignored in this build");
`endif
    endtask

    // One clock: check every output against the model, then advance the model.
    task automatic tick();
        int dx, dy, wx, wy, wc, e_addr, e_wd;
        bit dreq, wv, clr, scr, doob, woob, rdy, e_we;
        #2;
        dreq = vif.disp_req;  dx = int'(vif.disp_x); dy = int'(vif.disp_y);
        wv   = vif.wr_valid;  wx = int'(vif.wr_x);   wy = int'(vif.wr_y);
        wc   = int'(vif.wr_char);
        clr  = vif.clr_start;
`ifdef VRAM_SCROLL_EN
        scr  = vif.scroll_req;
`else
        scr  = 1'b0;
`endif
        if (!reset_n) begin
            sq.delete(); m_rb = 0; m_live = 0; m_dv = 0; m_dd = 8'h00; m_werr = 0;
        end
        doob = (dx >= C) || (dy >= R);
        woob = (wx >= C) || (wy >= R);
        rdy  = m_live && (sq.size() == 0) && !dreq && !clr;
        e_we = 0; e_addr = 0; e_wd = 0;
        if (m_live) begin
            if (dreq) begin
                if (!doob) e_addr = paddr(dx, dy);
            end else if (sq.size() > 0) begin
                e_addr = sq[0]; e_we = 1; e_wd = int'(BL);
            end else if (wv && rdy && !woob) begin
                e_addr = paddr(wx, wy); e_we = 1; e_wd = wc;
            end
        end
        chk("mem_we", int'(vif.mem_we), int'(e_we));
        chk("mem_addr", int'(vif.mem_addr), e_addr);
        chk("mem_wdata", int'(vif.mem_wdata), e_wd);
        chk("busy", int'(vif.busy), int'(sq.size() > 0));
        if (m_live) chk("wr_ready", int'(vif.wr_ready), int'(rdy));
        chk("disp_vld", int'(vif.disp_vld), int'(m_dv));
        if (m_dv || !m_live) chk("disp_data", int'(vif.disp_data), m_dv ? int'(m_dd) : 0);
        chk("wr_err", int'(vif.wr_err), int'(m_werr));
        if (reset_n) begin
            if (!m_live) begin
                m_live = 1; m_dv = 0; m_werr = 0;
            end else begin
                m_dv = dreq;
                if (dreq) m_dd = doob ? BL : shadow[e_addr];
                if (e_we) shadow[e_addr] = 8'(e_wd);
                m_werr = wv && rdy && woob;
                if (sq.size() > 0) begin
                    if (!dreq) void'(sq.pop_front());
                end else if (clr) begin
                    m_rb = 0;
                    for (int i = 0; i < C * R; i++) sq.push_back(i);
                end else if (scr) begin
                    for (int x = 0; x < C; x++) sq.push_back(m_rb * C + x);
                    m_rb = (m_rb + 1) % R;
                end
            end
        end
        @(posedge pclk);
        @(negedge pclk);
    endtask

    function automatic vec_t mk(input bit dreq, input int dx, input int dy, input bit wv,
                                input int wx, input int wy, input int wc, input bit e_rdy,
                                input bit e_we, input int e_addr, input int e_wd,
                                input bit e_dv, input int e_dd, input bit e_err);
        vec_t v;
        v.dreq = dreq; v.dx = dx; v.dy = dy; v.wv = wv; v.wx = wx; v.wy = wy; v.wc = wc;
        v.e_rdy = e_rdy; v.e_we = e_we; v.e_addr = e_addr; v.e_wd = e_wd;
        v.e_dv = e_dv; v.e_dd = e_dd; v.e_err = e_err;
        return v;
    endfunction

    initial begin
        int nd, cyc, bad, dx, dy;
        for (int i = 0; i < VRAM_DEPTH; i++) shadow[i] = 8'hFF;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        set_scroll(0);
        //            dreq dx dy  wv wx wy wc     rdy we addr  wd    dv dd    err
        tbl[0]  = mk(0,  0, 0,  1, 3, 2, 'h41, 1, 1, 143,  'h41, 0, 0,    0);
        tbl[1]  = mk(1,  3, 2,  0, 0, 0, 0,    0, 0, 143,  0,    0, 0,    0);
        tbl[2]  = mk(0,  0, 0,  0, 0, 0, 0,    1, 0, 0,    0,    1, 'h41, 0);
        tbl[3]  = mk(0,  0, 0,  1, 70, 0, 'h42, 1, 0, 0,   0,    0, 0,    0);
        tbl[4]  = mk(0,  0, 0,  0, 0, 0, 0,    1, 0, 0,    0,    0, 0,    1);
        tbl[5]  = mk(1,  70, 5, 0, 0, 0, 0,    0, 0, 0,    0,    0, 0,    0);
        tbl[6]  = mk(0,  0, 0,  0, 0, 0, 0,    1, 0, 0,    0,    1, 'h20, 0);
        tbl[7]  = mk(1,  1, 0,  1, 69, 29, 'h5A, 0, 0, 1,  0,    0, 0,    0);
        tbl[8]  = mk(0,  0, 0,  1, 69, 29, 'h5A, 1, 1, 2099, 'h5A, 1, 'hFF, 0);
        tbl[9]  = mk(1,  69, 29, 0, 0, 0, 0,   0, 0, 2099, 0,    0, 0,    0);
        tbl[10] = mk(0,  0, 0,  0, 0, 0, 0,    1, 0, 0,    0,    1, 'h5A, 0);
        tbl[11] = mk(0,  0, 0,  1, 0, 30, 'h43, 1, 0, 0,   0,    0, 0,    0);
        tbl[12] = mk(1,  0, 0,  0, 0, 0, 0,    0, 0, 0,    0,    0, 0,    1);
        tbl[13] = mk(0,  0, 0,  0, 0, 0, 0,    1, 0, 0,    0,    1, 'hFF, 0);

        // Reset, with requests asserted to show they are ignored.
        @(negedge pclk);
        tick();
        mem_init = 1'b0;
        drive(1, 3, 3, 1, 4, 4, 'h55, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset_n = 1'b1;
        tick();

        foreach (tbl[i]) begin
            drive(tbl[i].dreq, tbl[i].dx, tbl[i].dy, tbl[i].wv, tbl[i].wx, tbl[i].wy, tbl[i].wc, 0);
            #1;
            chk($sformatf("v%0d_ready", i), int'(vif.wr_ready), int'(tbl[i].e_rdy));
            chk($sformatf("v%0d_we", i), int'(vif.mem_we), int'(tbl[i].e_we));
            chk($sformatf("v%0d_addr", i), int'(vif.mem_addr), tbl[i].e_addr);
            chk($sformatf("v%0d_wdata", i), int'(vif.mem_wdata), tbl[i].e_wd);
            chk($sformatf("v%0d_vld", i), int'(vif.disp_vld), int'(tbl[i].e_dv));
            if (tbl[i].e_dv) chk($sformatf("v%0d_data", i), int'(vif.disp_data), tbl[i].e_dd);
            chk($sformatf("v%0d_err", i), int'(vif.wr_err), int'(tbl[i].e_err));
            tick();
        end

        // Display held high starves the writer; the write lands when it drops.
        for (int i = 0; i < 6; i++) begin
            drive(1, 10 + i, 10, 1, 5, 5, 'h51, 0);
            #1;
            chk("hold_ready", int'(vif.wr_ready), 0);
            tick();
        end
        drive(0, 0, 0, 1, 5, 5, 'h51, 0);
        #1;
        chk("drop_ready", int'(vif.wr_ready), 1);
        chk("drop_we", int'(vif.mem_we), 1);
        chk("drop_addr", int'(vif.mem_addr), 355);
        tick();

        // Clear and write in the same cycle: clear wins.
        drive(0, 0, 0, 1, 1, 1, 'h78, 1);
        #1;
        chk("clr_wr_ready", int'(vif.wr_ready), 0);
        chk("clr_wr_we", int'(vif.mem_we), 0);
        tick();

        // Clear sweep with display at 50% duty; count non-display busy cycles.
        nd = 0; cyc = 0;
        while (cyc < 6000) begin
            drive(cyc % 2, $urandom_range(0, C - 1), $urandom_range(0, R - 1), 1, 2, 2, 'h33, 0);
            #1;
            if (!vif.busy) break;
            if (cyc % 2 == 0) nd++;
            tick();
            cyc++;
        end
        chk("clear_cycles", nd, 2100);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        bad = 0;
        for (int i = 0; i <= C * R; i++) begin
            if (i < C * R) drive(1, i % C, i / C, 0, 0, 0, 0, 0);
            else drive(0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            if (i > 0 && vif.disp_data !== BL) bad++;
            tick();
        end
        chk("clear_readback_bad", bad, 0);

        // Reset while the sweep is at cell 1000, then restart from address 0.
        drive(0, 0, 0, 1, 6, 6, 'h61, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cyc = 0;
        while (sq.size() > 0 && sq[0] != 1000 && cyc < 3000) begin
            tick();
            cyc++;
        end
        chk("sweep_reached_1000", (sq.size() > 0) ? sq[0] : -1, 1000);
        reset_n = 1'b0;
        #1;
        chk("rst_busy", int'(vif.busy), 0);
        chk("rst_we", int'(vif.mem_we), 0);
        chk("rst_addr", int'(vif.mem_addr), 0);
        chk("rst_wdata", int'(vif.mem_wdata), 0);
        chk("rst_vld", int'(vif.disp_vld), 0);
        chk("rst_err", int'(vif.wr_err), 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("restart_addr", int'(vif.mem_addr), 0);
        chk("restart_we", int'(vif.mem_we), 1);
        cyc = 0;
        while (vif.busy && cyc < 5000) begin
            tick();
            cyc++;
        end
        chk("restart_done", int'(vif.busy), 0);

`ifdef VRAM_SCROLL_EN
        // Scroll from row_base 0: physical row 0 is blanked, logical row 29 maps to it.
        drive(0, 0, 0, 1, 9, 0, 'h4B, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        set_scroll(1);
        tick();
        set_scroll(0);
        for (int i = 0; i < C; i++) begin
            #1;
            chk("scroll_addr", int'(vif.mem_addr), i);
            chk("scroll_we", int'(vif.mem_we), 1);
            tick();
        end
        #1;
        chk("scroll_done", int'(vif.busy), 0);
        drive(1, 0, 29, 0, 0, 0, 0, 0);
        #1;
        chk("scroll_wrap_addr", int'(vif.mem_addr), 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
`endif

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            dx = ($urandom_range(0, 7) == 0) ? $urandom_range(C, 127) : $urandom_range(0, C - 1);
            dy = ($urandom_range(0, 7) == 0) ? $urandom_range(R, 31) : $urandom_range(0, R - 1);
            drive($urandom_range(0, 9) < 4, dx, dy, $urandom_range(0, 1),
                  ($urandom_range(0, 9) == 0) ? $urandom_range(C, 127) : $urandom_range(0, C - 1),
                  ($urandom_range(0, 9) == 0) ? $urandom_range(R, 31) : $urandom_range(0, R - 1),
                  $urandom_range(0, 255), $urandom_range(0, 1499) == 0);
            set_scroll($urandom_range(0, 199) == 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        set_scroll(0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
